// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one request per instruction, buffers the
// returned word for decode, and latches a sticky fault on misalignment or timeout.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 255
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [63:0] NextPC,
    output logic [63:0] CurrentPC,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [63:0] ImemAddr,
    input  logic        ImemRespValid,
    input  logic [31:0] ImemRespData,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    input  logic        DecodeReady,
    output logic        FetchFault
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    // An 8-bit counter can only ever reach 255, so larger limits saturate there.
    localparam logic [8:0] TIMEOUT_W = (TIMEOUT > 255) ? 9'd255 : 9'(TIMEOUT);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [8:0] wait_cnt_inc;

    assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= S_REQ;
            CurrentPC   <= RESET_PC;
            InstrValid  <= 1'b0;
            Instruction <= 32'h0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (ImemReqReady) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (ImemRespValid) begin
                        Instruction <= ImemRespData;
                        InstrValid  <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt_inc[7:0];
                        if (wait_cnt_inc >= TIMEOUT_W)
                            state <= S_FAULT;
                    end
                end
                S_HOLD: begin
                    // Misaligned targets are still loaded so debug can see them.
                    if (DecodeReady) begin
                        CurrentPC  <= NextPC;
                        InstrValid <= 1'b0;
                        state      <= (NextPC[1:0] == 2'b00) ? S_REQ : S_FAULT;
                    end
                end
                default: state <= S_FAULT;
            endcase
        end
    end

    // Reset gating keeps the request low during the reset pulse itself.
    assign ImemReqValid = (state == S_REQ) && !Reset;
    assign ImemAddr     = CurrentPC;
    assign FetchFault   = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch transactions checked against a transaction-level PC/instruction model.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] NextPC;
    logic [63:0] CurrentPC;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [63:0] ImemAddr;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic        DecodeReady;
    logic        FetchFault;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [63:0] model_pc;

    fetch_unit dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .NextPC       (NextPC),
        .CurrentPC    (CurrentPC),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRespValid(ImemRespValid),
        .ImemRespData (ImemRespData),
        .InstrValid   (InstrValid),
        .Instruction  (Instruction),
        .DecodeReady  (DecodeReady),
        .FetchFault   (FetchFault)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete fetch: request stall rd, response latency wd, decode stall dd.
    task automatic do_fetch(input logic [31:0] word, input logic [63:0] nxt,
                            input int rd, input int wd, input int dd);
        logic aligned;
        aligned = (nxt[1:0] == 2'b00);
        total_cnt++;
        if (ImemReqValid !== 1'b1 || ImemAddr !== model_pc)
            $display("FAIL req_issue: valid=%b addr=%h, expected valid=1 addr=%h", ImemReqValid, ImemAddr, model_pc);
        else pass_cnt++;
        for (int i = 0; i < rd; i++) begin
            ImemReqReady  = 1'b0;
            ImemRespValid = 1'($urandom % 2);
            ImemRespData  = $urandom;
            DecodeReady   = 1'($urandom % 2);
            step();
            total_cnt++;
            if (ImemReqValid !== 1'b1 || ImemAddr !== model_pc || InstrValid !== 1'b0 || CurrentPC !== model_pc)
                $display("FAIL req_stall: valid=%b addr=%h ivalid=%b pc=%h, expected 1/%h/0/%h", ImemReqValid, ImemAddr, InstrValid, CurrentPC, model_pc, model_pc);
            else pass_cnt++;
        end
        ImemReqReady  = 1'b1;
        ImemRespValid = 1'($urandom % 2);
        ImemRespData  = $urandom;
        step();
        ImemReqReady  = 1'b0;
        ImemRespValid = 1'b0;
        total_cnt++;
        if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0)
            $display("FAIL wait_entry: reqvalid=%b ivalid=%b, expected 0/0", ImemReqValid, InstrValid);
        else pass_cnt++;
        for (int i = 0; i < wd; i++) begin
            DecodeReady = 1'($urandom % 2);
            NextPC      = {$urandom, $urandom};
            step();
            total_cnt++;
            if (ImemReqValid !== 1'b0 || InstrValid !== 1'b0 || FetchFault !== 1'b0 || CurrentPC !== model_pc)
                $display("FAIL wait_hold: reqvalid=%b ivalid=%b fault=%b pc=%h, expected 0/0/0/%h", ImemReqValid, InstrValid, FetchFault, CurrentPC, model_pc);
            else pass_cnt++;
        end
        ImemRespValid = 1'b1;
        ImemRespData  = word;
        step();
        ImemRespValid = 1'b0;
        total_cnt++;
        if (InstrValid !== 1'b1 || Instruction !== word || CurrentPC !== model_pc || ImemReqValid !== 1'b0)
            $display("FAIL capture: ivalid=%b instr=%h pc=%h reqvalid=%b, expected 1/%h/%h/0", InstrValid, Instruction, CurrentPC, ImemReqValid, word, model_pc);
        else pass_cnt++;
        for (int i = 0; i < dd; i++) begin
            DecodeReady   = 1'b0;
            ImemRespValid = 1'($urandom % 2);
            ImemRespData  = $urandom;
            NextPC        = {$urandom, $urandom};
            step();
            total_cnt++;
            if (InstrValid !== 1'b1 || Instruction !== word || CurrentPC !== model_pc || ImemReqValid !== 1'b0)
                $display("FAIL hold_stall: ivalid=%b instr=%h pc=%h reqvalid=%b, expected 1/%h/%h/0", InstrValid, Instruction, CurrentPC, ImemReqValid, word, model_pc);
            else pass_cnt++;
        end
        ImemRespValid = 1'b0;
        DecodeReady   = 1'b1;
        NextPC        = nxt;
        step();
        DecodeReady   = 1'b0;
        model_pc      = nxt;
        total_cnt++;
        if (CurrentPC !== nxt || InstrValid !== 1'b0 || FetchFault !== !aligned || ImemReqValid !== aligned)
            $display("FAIL retire: pc=%h ivalid=%b fault=%b reqvalid=%b, expected %h/0/%b/%b", CurrentPC, InstrValid, FetchFault, ImemReqValid, nxt, !aligned, aligned);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        NextPC = '0; ImemReqReady = 1'b0; ImemRespValid = 1'b0; ImemRespData = '0; DecodeReady = 1'b0;
        model_pc = 64'h0;
        step();
        step();
        total_cnt++;
        if (CurrentPC !== 64'h0 || ImemReqValid !== 1'b0 || InstrValid !== 1'b0 || Instruction !== 32'h0 || FetchFault !== 1'b0)
            $display("FAIL reset_state: pc=%h reqvalid=%b ivalid=%b instr=%h fault=%b, expected 0/0/0/0/0", CurrentPC, ImemReqValid, InstrValid, Instruction, FetchFault);
        else pass_cnt++;
        Reset = 1'b0;
        #1;
        total_cnt++;
        if (ImemReqValid !== 1'b1 || ImemAddr !== 64'h0)
            $display("FAIL reset_release: reqvalid=%b addr=%h, expected 1/0", ImemReqValid, ImemAddr);
        else pass_cnt++;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #1;
        total_cnt++;
        if (CurrentPC !== 64'h0 || FetchFault !== 1'b0 || ImemReqValid !== 1'b0 || InstrValid !== 1'b0)
            $display("FAIL reset_pulse: pc=%h fault=%b reqvalid=%b ivalid=%b, expected 0/0/0/0", CurrentPC, FetchFault, ImemReqValid, InstrValid);
        else pass_cnt++;
        step();
        Reset = 1'b0;
        model_pc = 64'h0;
        #1;
    endtask

    task automatic test_basic();
        do_fetch(32'h8B020020, 64'h4, 0, 0, 0);
        do_fetch(32'h12345678, 64'h8, 5, 2, 0);
        do_fetch(32'hCAFEF00D, 64'h10, 0, 0, 4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            logic [63:0] nxt;
            nxt = {$urandom, $urandom} & ~64'h3;
            do_fetch($urandom, nxt, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3));
        end
    endtask

    task automatic test_misaligned();
        do_fetch(32'hDEADBEEF, 64'h102, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            ImemReqReady = 1'b1; ImemRespValid = 1'b1; DecodeReady = 1'b1; NextPC = 64'h200;
            step();
            total_cnt++;
            if (FetchFault !== 1'b1 || ImemReqValid !== 1'b0 || CurrentPC !== 64'h102 || InstrValid !== 1'b0)
                $display("FAIL fault_sticky: fault=%b reqvalid=%b pc=%h ivalid=%b, expected 1/0/102/0", FetchFault, ImemReqValid, CurrentPC, InstrValid);
            else pass_cnt++;
        end
        ImemReqReady = 1'b0; ImemRespValid = 1'b0; DecodeReady = 1'b0;
        pulse_reset();
    endtask

    task automatic test_timeout();
        ImemReqReady = 1'b1;
        step();
        ImemReqReady = 1'b0;
        repeat (254) step();
        total_cnt++;
        if (FetchFault !== 1'b0 || ImemReqValid !== 1'b0)
            $display("FAIL timeout_early: fault=%b reqvalid=%b after 254 wait cycles, expected 0/0", FetchFault, ImemReqValid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (FetchFault !== 1'b1 || ImemReqValid !== 1'b0)
            $display("FAIL timeout_fire: fault=%b reqvalid=%b after 255 wait cycles, expected 1/0", FetchFault, ImemReqValid);
        else pass_cnt++;
        ImemRespValid = 1'b1; ImemRespData = 32'hA5A5A5A5;
        step();
        ImemRespValid = 1'b0;
        total_cnt++;
        if (InstrValid !== 1'b0 || FetchFault !== 1'b1 || Instruction !== 32'h0)
            $display("FAIL late_resp: ivalid=%b fault=%b instr=%h, expected 0/1/0", InstrValid, FetchFault, Instruction);
        else pass_cnt++;
        pulse_reset();
        total_cnt++;
        if (ImemReqValid !== 1'b1 || CurrentPC !== 64'h0 || FetchFault !== 1'b0)
            $display("FAIL timeout_recover: reqvalid=%b pc=%h fault=%b, expected 1/0/0", ImemReqValid, CurrentPC, FetchFault);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        do_fetch(32'h0BADC0DE, 64'h40, 0, 0, 0);
        ImemReqReady = 1'b1;
        step();
        ImemReqReady = 1'b0;
        step();
        Reset = 1'b1;
        #1;
        total_cnt++;
        if (ImemReqValid !== 1'b0 || CurrentPC !== 64'h0 || InstrValid !== 1'b0)
            $display("FAIL midwait_reset: reqvalid=%b pc=%h ivalid=%b, expected 0/0/0", ImemReqValid, CurrentPC, InstrValid);
        else pass_cnt++;
        step();
        Reset = 1'b0;
        model_pc = 64'h0;
        ImemRespValid = 1'b1; ImemRespData = 32'h77777777;
        step();
        ImemRespValid = 1'b0;
        total_cnt++;
        if (InstrValid !== 1'b0 || ImemReqValid !== 1'b1 || ImemAddr !== 64'h0 || Instruction !== 32'h0)
            $display("FAIL stale_resp: ivalid=%b reqvalid=%b addr=%h instr=%h, expected 0/1/0/0", InstrValid, ImemReqValid, ImemAddr, Instruction);
        else pass_cnt++;
        do_fetch(32'h13579BDF, 64'h4, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a fetch fault.
REQ-003 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 NextPC  input  64  next-PC value from the next-PC logic, sampled when an instruction retires.
REQ-006 CurrentPC  output  64  architectural PC register; feeds the next-PC logic and instruction memory.
REQ-007 ImemReqValid  output  1  instruction-memory request valid.
REQ-008 ImemReqReady  input  1  instruction memory accepts the request.
REQ-009 ImemAddr  output  64  request address; always equals CurrentPC.
REQ-010 ImemRespValid  input  1  response data valid, for one cycle per accepted request.
REQ-011 ImemRespData  input  32  fetched instruction word.
REQ-012 InstrValid  output  1  Instruction holds a valid fetched word for decode.
REQ-013 Instruction  output  32  buffered instruction word.
REQ-014 DecodeReady  input  1  decode/execute consumes the instruction this cycle.
REQ-015 FetchFault  output  1  sticky fault: misaligned NextPC or memory timeout.

Function
REQ-016 The FSM SHALL have four states: REQ, WAIT, HOLD and FAULT.
REQ-017 REQ: ImemReqValid=1; on ImemReqReady=1 the FSM SHALL go to WAIT; otherwise it stays in REQ and CurrentPC is unchanged.
REQ-018 WAIT: ImemReqValid=0; on ImemRespValid=1 the block SHALL capture ImemRespData into Instruction, set InstrValid=1 in the following cycle, and go to HOLD.
REQ-019 ImemRespValid SHALL be ignored in every state other than WAIT.
REQ-020 WAIT SHALL count cycles from 0; when the count reaches TIMEOUT without a response, the FSM SHALL go to FAULT.
REQ-021 HOLD: InstrValid=1 and Instruction is stable; when DecodeReady=1, CurrentPC SHALL load NextPC and InstrValid SHALL clear on the same edge.
REQ-022 On that HOLD retire edge, the FSM SHALL go to REQ if NextPC[1:0]==2'b00, else to FAULT.
REQ-023 CurrentPC SHALL change only on a HOLD retire or on reset; a misaligned NextPC is still loaded so it can be observed for debug.
REQ-024 FAULT: FetchFault=1, ImemReqValid=0, InstrValid=0; the FSM stays in FAULT until Reset.
REQ-025 Throughput: at best one instruction per 3 cycles (REQ, WAIT with an immediate response, HOLD with DecodeReady already high).
REQ-026 DecodeReady SHALL have no effect outside HOLD.
REQ-027 The WAIT counter is 8 bits, SHALL clear on entry to WAIT, and SHALL never wrap.
REQ-028 ImemAddr SHALL be driven from the CurrentPC register (no combinational path from NextPC).
REQ-029 All outputs SHALL be registered or decoded only from the state and registers.

Reset
REQ-030 While Reset=1, asynchronously: CurrentPC=RESET_PC, state=REQ, InstrValid=0, Instruction=32'h0, FetchFault=0, WAIT counter=0.
REQ-031 ImemReqValid SHALL be 0 while Reset=1, and 1 in the first cycle after Reset deasserts.
REQ-032 A Reset asserted mid-WAIT SHALL abandon the transaction; a response arriving after reset while in REQ SHALL be ignored.
REQ-033 Reset SHALL clear FetchFault and leave the FAULT state.

Verification
REQ-034 Reset release, ReqReady=1, response 1 cycle later with 32'h8B020020, DecodeReady=1, NextPC=4 -> InstrValid for 1 cycle with 32'h8B020020, then CurrentPC=4 and a new request at address 4.
REQ-035 ReqReady held low for 5 cycles -> ImemReqValid stays 1 and ImemAddr is stable at 0 throughout; WAIT is entered only after ReqReady=1.
REQ-036 DecodeReady low for 4 cycles in HOLD -> Instruction and InstrValid are stable and CurrentPC is unchanged; retire occurs on the first DecodeReady=1.
REQ-037 NextPC=64'h102 at retire -> CurrentPC=64'h102, FetchFault=1 on the next cycle, no further requests.
REQ-038 No response for 255 cycles in WAIT -> FetchFault=1; a response arriving later is ignored; Reset then restores CurrentPC=RESET_PC and FetchFault=0.
REQ-039 Reset asserted during WAIT, response arrives in the first post-reset cycle -> InstrValid stays 0 and the request is re-issued at RESET_PC.
